vga_box_anim: RTL and testbench

VGA_BOX_ANIM -- requirements
Module: vga_box_anim

---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_box_axis.sv | 64 ++++++
 rtl/vga_box_anim.sv | 80 ++++++++
 tb/tb_vga_box_anim.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the VGA bouncing-box animation: active extent,
// motion-state encoding and the box colour palette.
package vga_pkg;

    localparam int H_ACT = 640;
    localparam int V_ACT = 480;

    // Motion state is {y_dir, x_dir}, where 0 means the positive direction.
    localparam logic [1:0] ST_DR = 2'b00;
    localparam logic [1:0] ST_DL = 2'b01;
    localparam logic [1:0] ST_UR = 2'b10;
    localparam logic [1:0] ST_UL = 2'b11;

    localparam logic [11:0] PAL_0 = 12'hF00;
    localparam logic [11:0] PAL_1 = 12'h0F0;
    localparam logic [11:0] PAL_2 = 12'h00F;
    localparam logic [11:0] PAL_3 = 12'hFFF;

    function automatic logic [11:0] palette(input logic [1:0] idx);
        case (idx)
            2'd0:    return PAL_0;
            2'd1:    return PAL_1;
            2'd2:    return PAL_2;
            default: return PAL_3;
        endcase
    endfunction

endpackage

// File: rtl/vga_box_axis.sv
// One axis of the bouncing box: position, direction and edge bounce,
// advanced only when update_i is high.
module vga_box_axis
    import vga_pkg::*;
#(
    parameter int EXTENT   = 640,
    parameter int BOX_SIZE = 32,
    parameter int STEP     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       update_i,
    output logic [9:0] pos_o,
    output logic       dir_o,
    output logic       dir_nxt_o
);

    localparam logic [10:0] MAX_POS = 11'(EXTENT - BOX_SIZE);
    localparam logic [10:0] STEP_W  = 11'(STEP);

    logic [9:0]  pos_q, pos_d;
    logic        dir_q, dir_d;
    logic [10:0] pos_ext;

    // Widened to 11 bits so pos + STEP can never wrap before the compare.
    assign pos_ext = {1'b0, pos_q};

    always_comb begin
        // NOTE: defaults first so every path assigns; this keeps the block free of latches.
        pos_d = pos_q;
        dir_d = dir_q;
        if (!dir_q) begin
            if ((pos_ext + STEP_W) >= MAX_POS) begin
                pos_d = MAX_POS[9:0];
                dir_d = 1'b1;
            end else begin
                pos_d = 10'(pos_ext + STEP_W);
            end
        end else begin
            if (pos_ext <= STEP_W) begin
                pos_d = '0;
                dir_d = 1'b0;
            end else begin
                pos_d = 10'(pos_ext - STEP_W);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= '0;
            dir_q <= 1'b0;
        end else if (update_i) begin
            // NOTE: non-blocking so every register samples pre-edge values.
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end

    assign pos_o     = pos_q;
    assign dir_o     = dir_q;
    assign dir_nxt_o = dir_d;

endmodule

// File: rtl/vga_box_anim.sv
// Bouncing coloured box over a flat background; the box moves once per
// frame and changes colour each time it bounces off an edge.
module vga_box_anim #(
    parameter int          H_ACT    = vga_pkg::H_ACT,
    parameter int          V_ACT    = vga_pkg::V_ACT,
    parameter int          BOX_SIZE = 32,
    parameter int          STEP     = 2,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic        move_en,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    output logic [11:0] pix_data
);

    import vga_pkg::*;

    logic        tick_q, tick_d;
    logic        update;
    logic [9:0]  box_x, box_y;
    logic        dir_x, dir_y, dir_x_nxt, dir_y_nxt;
    logic [1:0]  state, state_nxt;
    logic [1:0]  color_idx_q, color_idx_d;
    logic [11:0] pix_data_q, pix_data_d;
    logic        in_active, in_box;

    // Last active pixel sampled -> one-cycle frame-end pulse next cycle.
    assign tick_d = (pix_x == 10'(H_ACT - 1)) && (pix_y == 10'(V_ACT - 1));
    assign update = tick_q & move_en;

    vga_box_axis #(.EXTENT(H_ACT), .BOX_SIZE(BOX_SIZE), .STEP(STEP)) u_axis_x (
        .clk      (vga_clk),
        .rst_n    (sys_rst_n),
        .update_i (update),
        .pos_o    (box_x),
        .dir_o    (dir_x),
        .dir_nxt_o(dir_x_nxt)
    );

    vga_box_axis #(.EXTENT(V_ACT), .BOX_SIZE(BOX_SIZE), .STEP(STEP)) u_axis_y (
        .clk      (vga_clk),
        .rst_n    (sys_rst_n),
        .update_i (update),
        .pos_o    (box_y),
        .dir_o    (dir_y),
        .dir_nxt_o(dir_y_nxt)
    );

    assign state     = {dir_y, dir_x};
    assign state_nxt = {dir_y_nxt, dir_x_nxt};

    // Any state change is a bounce; a corner changes both bits but bumps once.
    assign color_idx_d = (update && (state_nxt != state)) ? color_idx_q + 2'd1 : color_idx_q;

    assign in_active = ({1'b0, pix_x} < 11'(H_ACT)) && ({1'b0, pix_y} < 11'(V_ACT));
    assign in_box    = ({1'b0, pix_x} >= {1'b0, box_x}) &&
                       ({1'b0, pix_x} <  ({1'b0, box_x} + 11'(BOX_SIZE))) &&
                       ({1'b0, pix_y} >= {1'b0, box_y}) &&
                       ({1'b0, pix_y} <  ({1'b0, box_y} + 11'(BOX_SIZE)));

    assign pix_data_d = !in_active ? 12'h000 :
                        in_box     ? palette(color_idx_q) : BG_COLOR;

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tick_q      <= 1'b0;
            color_idx_q <= 2'd0;
            pix_data_q  <= 12'h000;
        end else begin
            tick_q      <= tick_d;
            color_idx_q <= color_idx_d;
            pix_data_q  <= pix_data_d;
        end
    end

    assign pix_data = pix_data_q;

endmodule

// File: tb/tb_vga_box_anim.sv
// Scoreboard bench for vga_box_anim: pixel requests push expected colours,
// a monitor pops and compares them one cycle later.
module tb_vga_box_anim;

    import vga_pkg::*;

    logic        vga_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        move_en   = 1'b0;
    logic [9:0]  pix_x     = '0;
    logic [9:0]  pix_y     = '0;
    logic [11:0] pix_data;

    typedef struct {
        string       name;
        logic [11:0] exp;
    } sb_t;

    sb_t sb[$];
    bit  req_valid = 1'b0;
    int  n_checks  = 0;
    int  n_pass    = 0;

    vga_box_anim dut (
        .vga_clk  (vga_clk),
        .sys_rst_n(sys_rst_n),
        .move_en  (move_en),
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .pix_data (pix_data)
    );

    always #20 vga_clk = ~vga_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input int x, input int y, input bit chk, input logic [11:0] exp,
                         input string nm);
        sb_t e;
        @(negedge vga_clk);
        pix_x     = 10'(x);
        pix_y     = 10'(y);
        req_valid = chk;
        if (chk) begin
            e.name = nm;
            e.exp  = exp;
            sb.push_back(e);
        end
    endtask

    task automatic pix(input int x, input int y, input logic [11:0] exp, input string nm);
        drive(x, y, 1'b1, exp, nm);
    endtask

    // Last active pixel, then blanking; the box moves on the edge after.
    task automatic frame_end();
        drive(639, 479, 1'b0, 12'h000, "");
        drive(700, 500, 1'b0, 12'h000, "");
        @(posedge vga_clk);
        #1;
    endtask

    task automatic run_frames(input int n);
        repeat (n) frame_end();
    endtask

    task automatic check_box(input string nm, input int x, input int y,
                             input logic [1:0] st, input logic [1:0] ci);
        check({nm, "_box_x"}, 32'(dut.box_x), 32'(x));
        check({nm, "_box_y"}, 32'(dut.box_y), 32'(y));
        check({nm, "_state"}, 32'(dut.state), 32'(st));
        check({nm, "_cidx"},  32'(dut.color_idx_q), 32'(ci));
    endtask

    // Monitor: a request seen at an edge has its pixel ready just after it.
    initial begin
        forever begin
            bit  v;
            sb_t e;
            @(posedge vga_clk);
            v = req_valid;
            #1;
            if (v) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL scoreboard_underflow: got pix_data %0h with no expected entry", pix_data);
                end else begin
                    e = sb.pop_front();
                    check(e.name, 32'(pix_data), 32'(e.exp));
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Held in reset with a pixel inside the box area.
        drive(0, 0, 1'b0, 12'h000, "");
        repeat (2) @(posedge vga_clk);
        #1;
        check("rst_hold_pix", 32'(pix_data), 32'h000);
        check("rst_hold_tick", 32'(dut.tick_q), 32'd0);
        check_box("rst_hold", 0, 0, ST_DR, 2'd0);
        @(negedge vga_clk);
        sys_rst_n = 1'b1;

        pix(0, 0, 12'hF00, "rel_p0_0");
        pix(32, 0, 12'h000, "rel_p32_0");
        pix(700, 10, 12'h000, "rel_p700_10");
        pix(31, 31, 12'hF00, "rel_p31_31");
        pix(0, 480, 12'h000, "rel_p0_480");

        move_en = 1'b1;
        frame_end();
        check_box("f1", 2, 2, ST_DR, 2'd0);
        pix(33, 33, 12'hF00, "f1_p33_33");
        pix(1, 1, 12'h000, "f1_p1_1");
        pix(34, 33, 12'h000, "f1_p34_33");
        pix(2, 2, 12'hF00, "f1_p2_2");

        // Y reaches its lower limit first: Y flips alone.
        run_frames(223);
        check_box("f224", 448, 448, ST_UR, 2'd1);
        pix(448, 448, 12'h0F0, "f224_p448_448");
        pix(479, 479, 12'h0F0, "f224_p479_479");
        pix(447, 460, 12'h000, "f224_p447_460");
        pix(460, 480, 12'h000, "f224_p460_480");

        run_frames(79);
        check_box("f303", 606, 290, ST_UR, 2'd1);
        frame_end();
        check_box("f304", 608, 288, ST_UL, 2'd2);
        pix(608, 288, 12'h00F, "f304_p608_288");
        pix(639, 319, 12'h00F, "f304_p639_319");
        pix(640, 300, 12'h000, "f304_p640_300");
        pix(607, 300, 12'h000, "f304_p607_300");
        frame_end();
        check_box("f305", 606, 286, ST_UL, 2'd2);

        // Freeze mid-frame for three frame ends.
        pix(100, 100, 12'h000, "frz_p100_100");
        move_en = 1'b0;
        run_frames(3);
        check_box("frz", 606, 286, ST_UL, 2'd2);
        pix(606, 286, 12'h00F, "frz_p606_286");

        // Frame 4256 is the first corner: both axes flip, colour 3 wraps to 0.
        move_en = 1'b1;
        run_frames(3950);
        check_box("f4255", 2, 446, ST_DL, 2'd3);
        pix(2, 446, 12'hFFF, "f4255_p2_446");
        pix(33, 477, 12'hFFF, "f4255_p33_477");
        frame_end();
        check_box("f4256", 0, 448, ST_UR, 2'd0);
        pix(0, 448, 12'hF00, "f4256_p0_448");
        pix(5, 450, 12'hF00, "pre_rst_p5_450");

        // Asynchronous reset between clock edges.
        drive(5, 450, 1'b0, 12'h000, "");
        @(posedge vga_clk);
        #5;
        sys_rst_n = 1'b0;
        #1;
        check("rst_async_pix", 32'(pix_data), 32'h000);
        check_box("rst_async", 0, 0, ST_DR, 2'd0);
        repeat (2) @(posedge vga_clk);
        @(negedge vga_clk);
        sys_rst_n = 1'b1;

        pix(0, 0, 12'hF00, "rel2_p0_0");
        frame_end();
        check_box("rel2_f1", 2, 2, ST_DR, 2'd0);

        drive(700, 500, 1'b0, 12'h000, "");
        repeat (2) @(posedge vga_clk);
        #2;
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
